fifo_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers in the wclk domain.
//  - Grants one requester at a time for a burst, ending on req_last or MAX_BURST beats.
//  - Drives winc/wdata and honours wfull back-pressure. Never writes to a full FIFO; never drops data.

---
 rtl/fifo_pkg.sv | 8 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO-side definitions: data width, write-arbiter defaults and FSM state type.
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_REQ    = 4;
  localparam int MAX_BURST  = 16;

  typedef enum logic {IDLE, BURST} wr_arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of i_req scanning upward from i_last_idx+1.
module rr_pick import fifo_pkg::*; #(
  parameter int N = fifo_pkg::NUM_REQ
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_last_idx,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_found
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] w_j;

  // Walk the ring from farthest to nearest so the nearest hit wins the last assignment.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_j     = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IDX_W'((int'(i_last_idx) + k) % N);
      if (i_req[w_j]) begin
        o_idx   = w_j;
        o_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the async FIFO write port; one burst per grant, ended by req_last
// or MAX_BURST beats, with wfull back-pressure applied combinationally to the owner.
module fifo_wr_arbiter import fifo_pkg::*; #(
  parameter int NUM_REQ    = fifo_pkg::NUM_REQ,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int MAX_BURST  = fifo_pkg::MAX_BURST
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic                          wfull
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  wr_arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [IDX_W-1:0]      r_last_idx, w_last_idx_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_found;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_glast;
  logic                  w_beat;
  logic                  w_release;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req      (req_valid),
    .i_last_idx (r_last_idx),
    .o_idx      (w_pick_idx),
    .o_found    (w_pick_found)
  );

  // Grant is one-hot, so an AND-OR mux selects the owner's data and last flag.
  always_comb begin
    w_gdata = '0;
    w_glast = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gdata = w_gdata | req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_glast = w_glast | req_last[i];
      end
    end
  end

  assign busy      = (r_state == BURST);
  assign grant     = r_grant;
  assign req_ready = busy ? (r_grant & {NUM_REQ{~wfull}}) : '0;
  assign w_beat    = |(req_valid & req_ready);
  assign winc      = w_beat;
  assign wdata     = w_beat ? w_gdata : '0;
  assign w_release = w_beat && (w_glast || (r_beat_cnt == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_idx_nxt = r_last_idx;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt    = BURST;
          w_grant_nxt    = NUM_REQ'(1) << w_pick_idx;
          w_last_idx_nxt = w_pick_idx;
          w_beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (w_beat) w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        if (w_release) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = '0;
          w_beat_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last_idx <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producer queues feed the DUT, a negedge monitor
// checks every cycle against a round-robin/burst model and per-requester expected data.
module tb_fifo_wr_arbiter;
  localparam int N = 4, W = 8, MB = 16, DEPTH = 64;

  logic         wclk = 1'b0, wrst = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0] req_ready, grant;
  logic         busy, winc, wfull = 1'b0;
  logic [W-1:0] wdata;

  always #6 wclk = ~wclk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .busy(busy),
    .winc(winc), .wdata(wdata), .wfull(wfull)
  );

  int n_chk = 0, n_err = 0;
  logic [W:0]   pq[N][$];     // {last,data} still to be offered by each producer
  logic [W-1:0] exp_q[N][$];  // data each requester must still see written, in order
  int bl_own[$], bl_len[$];   // completed bursts: owner and beat count
  logic [N-1:0] acc = '0;
  logic wr_s = 1'b0, force_full = 1'b0;
  int fifo_cnt = 0, rd_pct = 100, gap_pct = 0, total_wr = 0, full_seen = 0;
  int seq[N];

  logic [N-1:0] p_grant = '0, p_valid = '0, m_eg;
  logic p_rst = 1'b1, p_rel = 1'b0;
  int m_last = N - 1, m_beats = 0, m_g, m_pk;
  logic [W-1:0] m_ed;

  task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int owner(input logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (g[k]) return k;
    return -1;
  endfunction

  // Monitor: settled values at negedge are what the next posedge will commit.
  always @(negedge wclk) begin
    acc  = '0;
    wr_s = 1'b0;
    if (wrst) begin
      p_rst = 1'b1; p_rel = 1'b0; p_grant = '0; m_last = N - 1; m_beats = 0;
    end else begin
      if (p_rst) m_eg = '0;
      else if (p_grant == '0) begin
        m_pk = pick(p_valid, m_last);
        m_eg = (m_pk >= 0) ? (N'(1) << m_pk) : '0;
        if (m_pk >= 0) begin m_last = m_pk; m_beats = 0; end
      end else begin
        m_eg = p_rel ? '0 : p_grant;
        if (p_rel) begin
          bl_own.push_back(owner(p_grant)); bl_len.push_back(m_beats); m_beats = 0;
        end
      end
      chk("grant", grant == m_eg, 32'(grant), 32'(m_eg));
      if (p_rst) chk("rst_outs", {busy, winc, wdata, req_ready} == '0,
                     32'({busy, winc, wdata, req_ready}), 0);
      chk("busy", busy == (grant != '0), 32'(busy), 32'(grant != '0));
      chk("req_ready", req_ready == (busy ? (grant & {N{~wfull}}) : '0), 32'(req_ready),
          32'(busy ? (grant & {N{~wfull}}) : '0));
      chk("winc_while_full", !(winc && wfull), 32'(winc), 0);
      chk("winc", winc == |(req_valid & req_ready), 32'(winc), 32'(|(req_valid & req_ready)));
      if (wfull) full_seen++;
      m_g = owner(grant);
      if (winc) begin
        if (m_g < 0) chk("winc_no_owner", 1'b0, 32'(grant), 1);
        else if (exp_q[m_g].size() == 0) chk("sb_unexpected_write", 1'b0, 32'(wdata), 0);
        else begin
          m_ed = exp_q[m_g].pop_front();
          chk("sb_data", wdata == m_ed, 32'(wdata), 32'(m_ed));
        end
        if (m_g >= 0) begin
          m_beats++;
          p_rel = req_last[m_g] || (m_beats == MB);
        end
        acc = req_valid & req_ready; wr_s = 1'b1; total_wr++;
      end else begin
        p_rel = 1'b0;
        chk("wdata_idle", wdata == '0, 32'(wdata), 0);
      end
      p_grant = grant; p_valid = req_valid; p_rst = 1'b0;
    end
  end

  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    pq[i].push_back({l, d});
    exp_q[i].push_back(d);
  endtask

  task automatic drive();
    logic [W:0] b;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
        b = pq[i][0];
        req_valid[i] = 1'b1; req_data[i*W +: W] = b[W-1:0]; req_last[i] = b[W];
      end else begin
        req_valid[i] = 1'b0; req_data[i*W +: W] = W'($urandom); req_last[i] = 1'($urandom_range(1));
      end
    end
    wfull = force_full || (fifo_cnt >= DEPTH);
  endtask

  task automatic step();
    @(posedge wclk); #1;
    for (int i = 0; i < N; i++) if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    if (wr_s) fifo_cnt++;
    if (fifo_cnt > 0 && $urandom_range(99) < rd_pct) fifo_cnt--;
    drive();
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += pq[i].size() + exp_q[i].size();
    return s;
  endfunction

  task automatic drain(input string nm, input int maxc);
    int k = 0;
    while ((pending() > 0 || busy) && k < maxc) begin step(); k++; end
    chk(nm, k < maxc, 32'(pending()), 0);
    step(); step();
  endtask

  task automatic clear_log();
    bl_own.delete(); bl_len.delete();
  endtask

  task automatic chk_burst(input string nm, input int idx, input int own, input int len);
    if (bl_own.size() <= idx) chk(nm, 1'b0, 32'(bl_own.size()), 32'(idx + 1));
    else begin
      chk({nm, "_owner"}, bl_own[idx] == own, 32'(bl_own[idx]), 32'(own));
      chk({nm, "_len"}, bl_len[idx] == len, 32'(bl_len[idx]), 32'(len));
    end
  endtask

  initial begin
    int base, k, len;
    for (int i = 0; i < N; i++) seq[i] = 0;
    repeat (3) @(posedge wclk);
    #1 wrst = 1'b0;
    drive();

    // All requesters valid, single-beat bursts: strict rotation from req0.
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, W'(i * 16 + r), 1'b1);
    drain("t2_drain", 200);
    chk("t2_nbursts", bl_own.size() == 8, 32'(bl_own.size()), 8);
    for (int j = 0; j < 5; j++) chk_burst("t2_rot", j, j % N, 1);
    clear_log();

    // Lone 3-beat burst from req1.
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    drain("t1_drain", 100);
    chk_burst("t1", 0, 1, 3);
    clear_log();

    // Back-pressure after the first beat of a 5-beat burst.
    for (int j = 1; j <= 5; j++) push(0, W'(8'hD0 + j), j == 5);
    base = total_wr; k = 0;
    while (total_wr < base + 1 && k < 50) begin step(); k++; end
    chk("t3_first_beat", k < 50, 32'(total_wr - base), 1);
    force_full = 1'b1; wfull = 1'b1;
    repeat (4) step();
    chk("t3_no_write_while_full", total_wr == base + 1, 32'(total_wr - base), 1);
    force_full = 1'b0;
    drain("t3_drain", 100);
    chk_burst("t3", 0, 0, 5);
    clear_log();

    // Long stream from req2 gets cut at MAX_BURST; req3 then takes its turn.
    for (int j = 0; j < 20; j++) push(2, W'(8'h80 + j), j == 19);
    step(); step();
    push(3, 8'h3C, 1'b1);
    drain("t4_drain", 400);
    chk_burst("t4_cap", 0, 2, 16);
    chk_burst("t4_next", 1, 3, 1);
    chk_burst("t4_rest", 2, 2, 4);
    clear_log();

    // Reset while beat 3 of a req1 burst is on the port.
    for (int j = 0; j < 6; j++) push(1, W'(8'h50 + j), j == 5);
    base = total_wr; k = 0;
    while (total_wr < base + 2 && k < 50) begin step(); k++; end
    chk("t5_two_beats", k < 50, 32'(total_wr - base), 2);
    for (int i = 0; i < N; i++) begin pq[i].delete(); exp_q[i].delete(); end
    wrst = 1'b1;
    @(posedge wclk); #1;
    wrst = 1'b0;
    drive();
    for (int i = 0; i < N; i++) push(i, W'(8'hE0 + i), 1'b1);
    drain("t5_drain", 100);
    chk_burst("t5_first_after_rst", 0, 0, 1);
    clear_log();

    // Random traffic against a 64-deep FIFO with a slow reader.
    rd_pct = 35; gap_pct = 25;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(99) < 8) begin
          len = $urandom_range(24, 1);
          for (int b = 0; b < len; b++) begin
            push(i, {2'(i), 6'(seq[i])}, b == len - 1);
            seq[i]++;
          end
        end
      end
      step();
    end
    rd_pct = 100; gap_pct = 0;
    drain("t6_drain", 2000);
    chk("t6_full_seen", full_seen > 0, 32'(full_seen), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 pending", pending());
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end
endmodule
